ps2_device_tx: RTL and testbench

- Keyboard-side PS/2 transmitter: turns key events (scan code plus make/break flag) into device-to-host PS/2 frames on ps2_clk/ps2_data.
- Break events emit the 0xF0 prefix frame, then the code frame.
- Drives the host-side keyboard receiver and keypress counter in simulation/NVBoard loopback, so they can be exercised without a physical keyboard.
- Open-drain modelling is out of scope: both lines are plain registered outputs.

---
 rtl/ps2_device_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_device_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// Keyboard-side PS/2 transmitter: converts key events into device-to-host frames,
// prefixing break events with a 0xF0 frame.
module ps2_device_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_code,
  input  logic       ev_break,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_W - 1);
  localparam logic [7:0]       BREAK_PFX = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BIT_HI,
    S_BIT_LO,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [7:0]           code_q, code_d;
  logic                 brk_q, brk_d;
  logic                 pfx_done_q, pfx_done_d;
  logic                 cur_pfx_q, cur_pfx_d;
  logic                 ps2_clk_q, ps2_clk_d;
  logic                 ps2_data_q, ps2_data_d;
  logic                 busy_q, busy_d;
  logic                 ev_ready_q, ev_ready_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]           byte_sel;

  // Next-state and registered-output computation; outputs follow the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    code_d      = code_q;
    brk_d       = brk_q;
    pfx_done_d  = pfx_done_q;
    cur_pfx_d   = cur_pfx_q;
    ps2_clk_d   = ps2_clk_q;
    ps2_data_d  = ps2_data_q;
    frame_cnt_d = frame_cnt_q;
    byte_sel    = code_q;

    case (state_q)
      S_IDLE: begin
        if (ev_valid && ev_ready_q) begin
          code_d     = ev_code;
          brk_d      = ev_break;
          pfx_done_d = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        cur_pfx_d  = brk_q && !pfx_done_q;
        byte_sel   = cur_pfx_d ? BREAK_PFX : code_q;
        pfx_done_d = brk_q;
        frame_d    = {1'b1, ~^byte_sel, byte_sel, 1'b0};
        idx_d      = '0;
        cnt_d      = '0;
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b0;
        state_d    = S_BIT_HI;
      end
      S_BIT_HI: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b0;
          state_d   = S_BIT_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BIT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            ps2_data_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'(1);
            state_d     = S_GAP;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            frame_d    = {1'b1, frame_q[FRAME_W-1:1]};
            ps2_data_d = frame_q[1];
            state_d    = S_BIT_HI;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = cur_pfx_q ? S_LOAD : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ev_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= '1;
      code_q      <= '0;
      brk_q       <= 1'b0;
      pfx_done_q  <= 1'b0;
      cur_pfx_q   <= 1'b0;
      ps2_clk_q   <= 1'b1;
      ps2_data_q  <= 1'b1;
      busy_q      <= 1'b0;
      ev_ready_q  <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      code_q      <= code_d;
      brk_q       <= brk_d;
      pfx_done_q  <= pfx_done_d;
      cur_pfx_q   <= cur_pfx_d;
      ps2_clk_q   <= ps2_clk_d;
      ps2_data_q  <= ps2_data_d;
      busy_q      <= busy_d;
      ev_ready_q  <= ev_ready_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ev_ready  = ev_ready_q;
  assign ps2_clk   = ps2_clk_q;
  assign ps2_data  = ps2_data_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: host-side sampling monitor with a byte scoreboard,
// phase-timing checks and directed event sequences.
module tb_ps2_device_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 8;
  localparam int MAKE_LAT  = 1 + 22 * CLK_DIV + GAP_CYCLES;
  localparam int BRK_LAT   = 2 + 44 * CLK_DIV + 2 * GAP_CYCLES;
  localparam int WAIT_MAX  = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  sb[$];
  logic [10:0] frames_log[$];

  ps2_device_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_break (ev_break),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host-side monitor: samples data on ps2_clk falling edges and checks phase timing.
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  int          hi_len = 0;
  int          lo_len = 0;
  int          nbits = 0;
  int          tmg_bad = 0;
  int          hi_run = 0;
  int          gap_before = 0;
  bit          measuring = 1'b0;
  int          rel_cnt = 0;
  logic [10:0] shreg = '0;
  logic [7:0]  prev_byte = '0;

  task automatic frame_done();
    logic [7:0] got;
    logic [7:0] e;
    got = shreg[8:1];
    check("sb_not_empty", 32'(sb.size() > 0), 32'(1));
    e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    check("frame_bits", 32'(shreg), 32'({1'b1, ~^e, e, 1'b0}));
    check("frame_timing", 32'(tmg_bad), 32'(0));
    if (prev_byte == 8'hF0) check("pfx_gap", 32'(gap_before), 32'(GAP_CYCLES + 1));
    if (prev_byte == 8'hF0 && got != 8'hF0) rel_cnt++;
    prev_byte = got;
    frames_log.push_back(shreg);
    nbits = 0;
    tmg_bad = 0;
    measuring = 1'b1;
    hi_run = 1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      nbits = 0; tmg_bad = 0; measuring = 1'b0; hi_len = 0; lo_len = 0;
      prev_clk = 1'b1; prev_data = 1'b1; prev_byte = '0;
    end else begin
      if (prev_clk && !ps2_clk) begin
        if (nbits > 0 && hi_len != int'(CLK_DIV)) tmg_bad++;
        if (ps2_data !== prev_data) tmg_bad++;
        shreg = {ps2_data, shreg[10:1]};
        nbits++;
        lo_len = 1;
      end else if (!prev_clk && ps2_clk) begin
        if (lo_len != int'(CLK_DIV)) tmg_bad++;
        hi_len = 1;
        if (nbits == 11) frame_done();
      end else if (ps2_clk) begin
        hi_len++;
        if (measuring) begin
          if (ps2_data) hi_run++;
          else begin gap_before = hi_run; measuring = 1'b0; end
        end
      end else begin
        lo_len++;
        if (ps2_data !== prev_data) tmg_bad++;
      end
      prev_clk = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic wait_ready(output int k);
    k = 0;
    while (ev_ready !== 1'b1 && k < WAIT_MAX) begin
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic run_event(input logic [7:0] code, input logic brk, input int exp_lat,
                           input string tag);
    int k;
    wait_ready(k);
    ev_valid = 1'b1; ev_code = code; ev_break = brk;
    if (brk) sb.push_back(8'hF0);
    sb.push_back(code);
    @(posedge clk); #1;
    ev_valid = 1'b0; ev_code = ~code; ev_break = ~brk;
    wait_ready(k);
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    logic [7:0] fc_exp;
    rst = 1'b1; ev_valid = 1'b0; ev_code = '0; ev_break = 1'b0;
    fc_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ps2_clk", 32'(ps2_clk), 32'(1));
    check("rst_ps2_data", 32'(ps2_data), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ev_ready", 32'(ev_ready), 32'(1));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    @(negedge clk) rst = 1'b0;

    // Make 0x1C
    frames_log.delete();
    run_event(8'h1C, 1'b0, MAKE_LAT, "make_1c");
    check("make_1c_frames", 32'(frames_log.size()), 32'(1));
    check("make_1c_bits", 32'(frames_log[0]), 32'h438);
    fc_exp = fc_exp + 8'd1;
    check("make_1c_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
    check("make_1c_busy_after", 32'(busy), 32'(0));

    // Break 0x1C
    frames_log.delete();
    run_event(8'h1C, 1'b1, BRK_LAT, "break_1c");
    check("break_1c_frames", 32'(frames_log.size()), 32'(2));
    check("break_1c_pfx_bits", 32'(frames_log[0]), 32'h7E0);
    check("break_1c_code_bits", 32'(frames_log[1]), 32'h438);
    fc_exp = fc_exp + 8'd2;
    check("break_1c_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
    check("break_1c_release_cnt", 32'(rel_cnt), 32'(1));

    // Parity corners
    frames_log.delete();
    run_event(8'h00, 1'b0, MAKE_LAT, "par_00");
    run_event(8'hFF, 1'b0, MAKE_LAT, "par_ff");
    run_event(8'h01, 1'b0, MAKE_LAT, "par_01");
    check("par_frames", 32'(frames_log.size()), 32'(3));
    check("par_00_bit", 32'(frames_log[0][9]), 32'(1));
    check("par_ff_bit", 32'(frames_log[1][9]), 32'(1));
    check("par_01_bit", 32'(frames_log[2][9]), 32'(0));
    fc_exp = fc_exp + 8'd3;
    check("par_frame_cnt", 32'(frame_cnt), 32'(fc_exp));

    // Back-to-back with ev_valid held
    frames_log.delete();
    wait_ready(k);
    ev_valid = 1'b1; ev_code = 8'h15; ev_break = 1'b0;
    sb.push_back(8'h15);
    @(posedge clk); #1;
    ev_break = 1'b1;
    sb.push_back(8'hF0);
    sb.push_back(8'h15);
    wait_ready(k);
    check("b2b_make_lat", 32'(k), 32'(MAKE_LAT));
    @(posedge clk); #1;
    check("b2b_ready_one_cycle", 32'(ev_ready), 32'(0));
    ev_valid = 1'b0;
    wait_ready(k);
    check("b2b_break_lat", 32'(k), 32'(BRK_LAT));
    check("b2b_frames", 32'(frames_log.size()), 32'(3));
    check("b2b_sb_drained", 32'(sb.size()), 32'(0));
    check("b2b_release_cnt", 32'(rel_cnt), 32'(2));
    fc_exp = fc_exp + 8'd3;
    check("b2b_frame_cnt", 32'(frame_cnt), 32'(fc_exp));

    // Reset after the fifth falling edge of a frame
    wait_ready(k);
    ev_valid = 1'b1; ev_code = 8'h1C; ev_break = 1'b0;
    sb.push_back(8'h1C);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    k = 0;
    while (nbits < 5 && k < WAIT_MAX) begin @(posedge clk); #2; k++; end
    check("rst_mid_falls", 32'(nbits), 32'(5));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ps2_clk", 32'(ps2_clk), 32'(1));
    check("rst_mid_ps2_data", 32'(ps2_data), 32'(1));
    check("rst_mid_ev_ready", 32'(ev_ready), 32'(1));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_frame_cnt", 32'(frame_cnt), 32'(0));
    sb.delete();
    @(negedge clk) rst = 1'b0;
    frames_log.delete();
    repeat (20) @(posedge clk);
    #1;
    check("rst_mid_no_partial", 32'(frames_log.size()), 32'(0));
    run_event(8'h1C, 1'b0, MAKE_LAT, "post_rst");
    check("post_rst_frames", 32'(frames_log.size()), 32'(1));
    check("post_rst_bits", 32'(frames_log[0]), 32'h438);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
